// File: rtl/axi_lite_pkg.sv
// Shared constants and FSM state types for the AXI-Lite register slave.
// Holds response codes, register byte offsets, register indices and the
// read/write FSM state enums used by axi_lite_reg_slave and its decoder.
package axi_lite_pkg;

  // AXI response codes
  localparam int unsigned RESP_OKAY   = 0;
  localparam int unsigned RESP_SLVERR = 2;

  // Register byte offsets relative to BASE_ADDR
  localparam int unsigned OFFS_CTRL0  = 0;
  localparam int unsigned OFFS_CTRL1  = 4;
  localparam int unsigned OFFS_SUM    = 8;
  localparam int unsigned OFFS_WCOUNT = 12;

  // Register index (offset / 4)
  localparam int unsigned REG_IDX_WIDTH = 2;
  localparam logic [REG_IDX_WIDTH-1:0] IDX_CTRL0  = REG_IDX_WIDTH'(OFFS_CTRL0 / 4);
  localparam logic [REG_IDX_WIDTH-1:0] IDX_CTRL1  = REG_IDX_WIDTH'(OFFS_CTRL1 / 4);
  localparam logic [REG_IDX_WIDTH-1:0] IDX_SUM    = REG_IDX_WIDTH'(OFFS_SUM / 4);
  localparam logic [REG_IDX_WIDTH-1:0] IDX_WCOUNT = REG_IDX_WIDTH'(OFFS_WCOUNT / 4);

  // Write channel FSM states
  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_WAIT_DATA = 2'd1,
    W_WAIT_ADDR = 2'd2,
    W_RESP      = 2'd3
  } w_state_e;

  // Read channel FSM states
  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi_lite_reg_decode.sv
// Combinational address decoder for the register map.
// Ports:
//   i_addr   - byte address from the bus
//   o_idx    - register index (offset / 4)
//   o_rd_ok  - address is aligned and inside the map (readable)
//   o_wr_ok  - address is readable and targets a writable register
module axi_lite_reg_decode
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic [ADDR_WIDTH-1:0]    i_addr,
  output logic [REG_IDX_WIDTH-1:0] o_idx,
  output logic                     o_rd_ok,
  output logic                     o_wr_ok
);

  logic [ADDR_WIDTH-1:0] w_offset;
  logic                  w_in_map;

  // Offset wraps modulo 2^ADDR_WIDTH, so addresses below BASE_ADDR land high and fail the range test
  assign w_offset = i_addr - ADDR_WIDTH'(BASE_ADDR);
  assign w_in_map = (w_offset[1:0] == 2'b00) && (w_offset <= ADDR_WIDTH'(OFFS_WCOUNT));

  assign o_idx   = w_offset[3:2];
  assign o_rd_ok = w_in_map;
  assign o_wr_ok = w_in_map && ((o_idx == IDX_CTRL0) || (o_idx == IDX_CTRL1));

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite slave with four 32-bit-spaced registers:
//   CTRL0 (RW), CTRL1 (RW), SUM = CTRL0+CTRL1 (RO), WCOUNT = OKAY write count (RO).
// Independent write and read FSMs; all bus outputs are registered.
// Ports:
//   s_axi_aclk / s_axi_areset          - clock, synchronous active-high reset
//   s_axi_aw* / s_axi_w* / s_axi_b*    - write address, data and response channels
//   s_axi_ar* / s_axi_r*               - read address and data channels
//   s_axi_wstrb has one extra top bit that is ignored
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  // Register file
  logic [DATA_WIDTH-1:0] r_ctrl0;
  logic [DATA_WIDTH-1:0] r_ctrl1;
  logic [DATA_WIDTH-1:0] r_wcount;
  logic [DATA_WIDTH-1:0] w_sum;

  // Write channel state and captured transaction
  w_state_e              r_wstate;
  w_state_e              w_wstate_nxt;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [RESP_WIDTH-1:0] r_bresp;
  logic                  w_awready_nxt;
  logic                  w_wready_nxt;
  logic                  w_bvalid_nxt;
  logic [RESP_WIDTH-1:0] w_bresp_nxt;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NBYTES-1:0]     r_wstrb;

  // Effective write payload at commit time
  logic [ADDR_WIDTH-1:0]    w_wr_addr;
  logic [DATA_WIDTH-1:0]    w_wr_data;
  logic [NBYTES-1:0]        w_wr_strb;
  logic [REG_IDX_WIDTH-1:0] w_wr_idx;
  logic                     w_wr_ok;
  logic                     w_wr_rd_ok;
  logic [DATA_WIDTH-1:0]    w_wr_old;
  logic [DATA_WIDTH-1:0]    w_wr_merged;

  // Read channel state
  r_state_e                 r_rstate;
  r_state_e                 w_rstate_nxt;
  logic                     r_arready;
  logic                     r_rvalid;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [RESP_WIDTH-1:0]    r_rresp;
  logic                     w_arready_nxt;
  logic                     w_rvalid_nxt;
  logic [DATA_WIDTH-1:0]    w_rdata_nxt;
  logic [RESP_WIDTH-1:0]    w_rresp_nxt;
  logic [REG_IDX_WIDTH-1:0] w_rd_idx;
  logic                     w_rd_ok;
  logic                     w_rd_wr_ok;
  logic [DATA_WIDTH-1:0]    w_rd_val;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;
  logic w_unused;

  assign w_aw_hs = s_axi_awvalid & r_awready;
  assign w_w_hs  = s_axi_wvalid & r_wready;
  assign w_ar_hs = s_axi_arvalid & r_arready;

  assign w_sum = r_ctrl0 + r_ctrl1;

  assign w_unused = ^{s_axi_wstrb[NBYTES], w_wr_rd_ok, w_rd_wr_ok};

  // Whichever half arrives on the commit edge is taken live; the other comes from its capture register
  assign w_wr_addr = (r_wstate == W_WAIT_DATA) ? r_awaddr : s_axi_awaddr;
  assign w_wr_data = (r_wstate == W_WAIT_ADDR) ? r_wdata  : s_axi_wdata;
  assign w_wr_strb = (r_wstate == W_WAIT_ADDR) ? r_wstrb  : s_axi_wstrb[NBYTES-1:0];

  axi_lite_reg_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_wr_decode (
    .i_addr  (w_wr_addr),
    .o_idx   (w_wr_idx),
    .o_rd_ok (w_wr_rd_ok),
    .o_wr_ok (w_wr_ok)
  );

  axi_lite_reg_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_rd_decode (
    .i_addr  (s_axi_araddr),
    .o_idx   (w_rd_idx),
    .o_rd_ok (w_rd_ok),
    .o_wr_ok (w_rd_wr_ok)
  );

  // Byte-lane merge of write data into the targeted control register
  always_comb begin
    w_wr_old    = (w_wr_idx == IDX_CTRL1) ? r_ctrl1 : r_ctrl0;
    w_wr_merged = w_wr_old;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (w_wr_strb[i]) begin
        w_wr_merged[i*8 +: 8] = w_wr_data[i*8 +: 8];
      end
    end
  end

  // Read value mux
  always_comb begin
    w_rd_val = r_ctrl0;
    case (w_rd_idx)
      IDX_CTRL0:  w_rd_val = r_ctrl0;
      IDX_CTRL1:  w_rd_val = r_ctrl1;
      IDX_SUM:    w_rd_val = w_sum;
      IDX_WCOUNT: w_rd_val = r_wcount;
      default:    w_rd_val = r_ctrl0;
    endcase
  end

  // Write FSM next-state and next-output logic
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_awready_nxt = r_awready;
    w_wready_nxt  = r_wready;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_commit      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready_nxt = 1'b1;
        w_wready_nxt  = 1'b1;
        if (w_aw_hs && w_w_hs) begin
          w_commit      = 1'b1;
          w_wstate_nxt  = W_RESP;
          w_awready_nxt = 1'b0;
          w_wready_nxt  = 1'b0;
        end else if (w_aw_hs) begin
          w_wstate_nxt  = W_WAIT_DATA;
          w_awready_nxt = 1'b0;
        end else if (w_w_hs) begin
          w_wstate_nxt = W_WAIT_ADDR;
          w_wready_nxt = 1'b0;
        end
      end
      W_WAIT_DATA: begin
        if (w_w_hs) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
          w_wready_nxt = 1'b0;
        end
      end
      W_WAIT_ADDR: begin
        if (w_aw_hs) begin
          w_commit      = 1'b1;
          w_wstate_nxt  = W_RESP;
          w_awready_nxt = 1'b0;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_wstate_nxt  = W_IDLE;
          w_bvalid_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
    if (w_commit) begin
      w_bvalid_nxt = 1'b1;
      w_bresp_nxt  = w_wr_ok ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
    end
  end

  // Write FSM registers
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  // Capture address/data at their own handshake; commit into the register file
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_ctrl0  <= '0;
      r_ctrl1  <= '0;
      r_wcount <= '0;
    end else begin
      if (w_aw_hs) begin
        r_awaddr <= s_axi_awaddr;
      end
      if (w_w_hs) begin
        r_wdata <= s_axi_wdata;
        r_wstrb <= s_axi_wstrb[NBYTES-1:0];
      end
      if (w_commit && w_wr_ok) begin
        if (w_wr_idx == IDX_CTRL1) begin
          r_ctrl1 <= w_wr_merged;
        end else begin
          r_ctrl0 <= w_wr_merged;
        end
        r_wcount <= r_wcount + DATA_WIDTH'(1);
      end
    end
  end

  // Read FSM next-state and next-output logic
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    case (r_rstate)
      R_IDLE: begin
        w_arready_nxt = 1'b1;
        if (w_ar_hs) begin
          w_rstate_nxt  = R_DATA;
          w_arready_nxt = 1'b0;
          w_rvalid_nxt  = 1'b1;
          w_rdata_nxt   = w_rd_ok ? w_rd_val : '0;
          w_rresp_nxt   = w_rd_ok ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          w_rstate_nxt  = R_IDLE;
          w_rvalid_nxt  = 1'b0;
          w_arready_nxt = 1'b1;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM registers
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= '0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;

endmodule
